// File: rtl/moore_pkg.sv
// Shared Moore detector encoding, next-state function and match decode.
// Latency: none, pure constants and combinational functions.
// Backpressure: not applicable.
package moore_pkg;

    localparam int STATE_W = 3;

    localparam logic [STATE_W-1:0] ST_A = 3'd0;
    localparam logic [STATE_W-1:0] ST_B = 3'd1;
    localparam logic [STATE_W-1:0] ST_C = 3'd2;
    localparam logic [STATE_W-1:0] ST_D = 3'd3;
    localparam logic [STATE_W-1:0] ST_E = 3'd4;

    function automatic logic is_match(input logic [STATE_W-1:0] state);
        return (state == ST_C) || (state == ST_E);
    endfunction

    // Illegal codes 5-7 fall back to A so a corrupted context self-recovers.
    function automatic logic [STATE_W-1:0] moore_next(input logic [STATE_W-1:0] state,
                                                      input logic b);
        case (state)
            ST_A:    return b ? ST_B : ST_D;
            ST_B:    return b ? ST_C : ST_D;
            ST_C:    return b ? ST_E : ST_C;
            ST_D:    return b ? ST_E : ST_D;
            ST_E:    return ST_E;
            default: return ST_A;
        endcase
    endfunction

endpackage

// File: rtl/moore_detect_sched_rr_sel.sv
// Round-robin channel pick with a burst quantum for the current owner.
// Latency: combinational, same cycle.
// Backpressure: ineligible channels are simply skipped; no state held here.
module rr_sel #(
    parameter int NCH     = 4,
    parameter int QUANTUM = 4
) (
    input  logic [NCH-1:0]               eligible,
    input  logic [$clog2(NCH)-1:0]       cur,
    input  logic [$clog2(QUANTUM+1)-1:0] cnt,
    output logic [$clog2(NCH)-1:0]       sel,
    output logic                         sel_valid,
    output logic                         hold
);

    localparam int CW = $clog2(NCH);

    int idx;

    always_comb begin
        hold      = eligible[cur] && (int'(cnt) < QUANTUM);
        sel       = cur;
        sel_valid = hold;
        idx       = 0;
        // Scan starts just after the owner, so the owner itself is tried last.
        if (!hold) begin
            for (int k = 1; k <= NCH; k++) begin
                idx = (int'(cur) + k) % NCH;
                if (!sel_valid && eligible[idx]) begin
                    sel       = CW'(idx);
                    sel_valid = 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/moore_detect_sched.sv
// Time-shares one Moore detector next-state function across NCH serial bit streams.
// Latency: bit accepted in cycle t is reported on the output registers in cycle t+1.
// Backpressure: req_ready grants at most one eligible channel per cycle; a cleared channel is never granted.
module moore_detect_sched
    import moore_pkg::*;
#(
    parameter int NCH     = 4,
    parameter int QUANTUM = 4
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic [NCH-1:0]           req_valid,
    input  logic [NCH-1:0]           req_bit,
    output logic [NCH-1:0]           req_ready,
    input  logic [NCH-1:0]           clr,
    output logic                     out_valid,
    output logic [$clog2(NCH)-1:0]   out_ch,
    output logic [STATE_W-1:0]       out_state,
    output logic                     out_match,
    output logic [NCH-1:0]           match
);

    localparam int CW = $clog2(NCH);
    localparam int NW = $clog2(QUANTUM+1);

    logic [STATE_W-1:0] ctx [NCH];
    logic [CW-1:0]      cur;
    logic [CW-1:0]      sel;
    logic [NW-1:0]      cnt;
    logic               sel_valid;
    logic               hold;
    logic [NCH-1:0]     eligible;
    logic [STATE_W-1:0] nxt;

    // Reset gates eligibility so no handshake can complete while reset is held.
    assign eligible = req_valid & ~clr & {NCH{reset_n}};

    rr_sel #(
        .NCH     (NCH),
        .QUANTUM (QUANTUM)
    ) u_rr_sel (
        .eligible  (eligible),
        .cur       (cur),
        .cnt       (cnt),
        .sel       (sel),
        .sel_valid (sel_valid),
        .hold      (hold)
    );

    always_comb begin
        req_ready = '0;
        if (sel_valid) req_ready[sel] = 1'b1;
    end

    assign nxt = moore_next(ctx[sel], req_bit[sel]);

    always_comb begin
        match = '0;
        for (int i = 0; i < NCH; i++) match[i] = is_match(ctx[i]);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < NCH; i++) ctx[i] <= ST_A;
            cur       <= '0;
            cnt       <= '0;
            out_valid <= 1'b0;
            out_ch    <= '0;
            out_state <= ST_A;
            out_match <= 1'b0;
        end else begin
            for (int i = 0; i < NCH; i++) begin
                if (clr[i])                               ctx[i] <= ST_A;
                else if (sel_valid && (sel == CW'(i)))    ctx[i] <= nxt;
            end
            if (sel_valid) begin
                cur <= sel;
                cnt <= hold ? cnt + 1'b1 : NW'(1);
            end else begin
                cnt <= '0;
            end
            out_valid <= sel_valid;
            if (sel_valid) begin
                out_ch    <= sel;
                out_state <= nxt;
                out_match <= is_match(nxt);
            end
        end
    end

endmodule

// File: tb/tb_moore_detect_sched.sv
// Directed-vector bench for moore_detect_sched with hand-computed expectations.
// Inputs change on the falling edge; outputs are sampled 1 time unit after an edge.
module tb_moore_detect_sched;

    localparam int NCH     = 4;
    localparam int QUANTUM = 4;

    logic           clk = 1'b0;
    logic           reset_n = 1'b0;
    logic [NCH-1:0] req_valid = '0;
    logic [NCH-1:0] req_bit = '0;
    logic [NCH-1:0] req_ready;
    logic [NCH-1:0] clr = '0;
    logic           out_valid;
    logic [1:0]     out_ch;
    logic [2:0]     out_state;
    logic           out_match;
    logic [NCH-1:0] match;

    int n_chk  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    moore_detect_sched #(
        .NCH     (NCH),
        .QUANTUM (QUANTUM)
    ) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .req_valid (req_valid),
        .req_bit   (req_bit),
        .req_ready (req_ready),
        .clr       (clr),
        .out_valid (out_valid),
        .out_ch    (out_ch),
        .out_state (out_state),
        .out_match (out_match),
        .match     (match)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic drive(input logic [3:0] v, input logic [3:0] b, input logic [3:0] c);
        @(negedge clk);
        req_valid = v;
        req_bit   = b;
        clr       = c;
        #1;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_out(input string tag, input logic [1:0] ch, input logic [2:0] st,
                             input logic m);
        check({tag, ".vld"}, 32'(out_valid), 32'd1);
        check({tag, ".ch"},  32'(out_ch),    32'(ch));
        check({tag, ".st"},  32'(out_state), 32'(st));
        check({tag, ".m"},   32'(out_match), 32'(m));
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset_n   = 1'b0;
        req_valid = '0;
        req_bit   = '0;
        clr       = '0;
        @(negedge clk);
        reset_n = 1'b1;
    endtask

    initial begin
        // Reset state, with requests already asserted to prove ready stays low.
        req_valid = 4'hF;
        repeat (2) @(posedge clk);
        #1;
        check("rst.ready", 32'(req_ready), 32'h0);
        check("rst.vld",   32'(out_valid), 32'h0);
        check("rst.ch",    32'(out_ch),    32'h0);
        check("rst.st",    32'(out_state), 32'h0);
        check("rst.m",     32'(out_match), 32'h0);
        check("rst.match", 32'(match),     32'h0);
        @(negedge clk);
        req_valid = '0;
        reset_n   = 1'b1;

        // Single channel decode: 1,1 -> B, C.
        drive(4'b0001, 4'b0001, 4'b0000);
        check("dec1.ready", 32'(req_ready), 32'b0001);
        tick(); check_out("dec1", 2'd0, 3'd1, 1'b0);
        drive(4'b0001, 4'b0001, 4'b0000);
        tick(); check_out("dec2", 2'd0, 3'd2, 1'b1);
        check("dec2.match", 32'(match), 32'b0001);

        // Clear ch0; output registers hold while idle.
        drive(4'b0000, 4'b0000, 4'b0001);
        check("clr0.ready", 32'(req_ready), 32'h0);
        tick();
        check("clr0.vld",   32'(out_valid), 32'd0);
        check("clr0.hold",  32'(out_state), 32'd2);
        check("clr0.match", 32'(match),     32'h0);

        // 1,0,1 -> B, D, E.
        drive(4'b0001, 4'b0001, 4'b0000); tick(); check_out("seq1", 2'd0, 3'd1, 1'b0);
        drive(4'b0001, 4'b0000, 4'b0000); tick(); check_out("seq2", 2'd0, 3'd3, 1'b0);
        drive(4'b0001, 4'b0001, 4'b0000); tick(); check_out("seq3", 2'd0, 3'd4, 1'b1);

        // Context preservation across interleaved channels.
        drive(4'b0000, 4'b0000, 4'b0001); tick();
        drive(4'b0001, 4'b0001, 4'b0000); tick(); check_out("ctx1", 2'd0, 3'd1, 1'b0);
        drive(4'b0010, 4'b0000, 4'b0000); tick(); check_out("ctx2", 2'd1, 3'd3, 1'b0);
        drive(4'b0010, 4'b0000, 4'b0000); tick(); check_out("ctx3", 2'd1, 3'd3, 1'b0);
        drive(4'b0001, 4'b0001, 4'b0000); tick(); check_out("ctx4", 2'd0, 3'd2, 1'b1);
        drive(4'b0010, 4'b0000, 4'b0000); tick(); check_out("ctx5", 2'd1, 3'd3, 1'b0);
        check("ctx5.match", 32'(match), 32'b0001);

        // clr collision on ch1: ch0 still served, ch1 restarts from A.
        drive(4'b0011, 4'b0000, 4'b0010);
        check("coll.ready", 32'(req_ready), 32'b0001);
        tick(); check_out("coll", 2'd0, 3'd2, 1'b1);
        drive(4'b0010, 4'b0010, 4'b0000); tick(); check_out("coll.ch1", 2'd1, 3'd1, 1'b0);

        // Fairness: four channels valid continuously, bursts of QUANTUM.
        do_reset();
        for (int k = 0; k < 20; k++) begin
            drive(4'b1111, 4'b0000, 4'b0000);
            check("fair.ready", 32'(req_ready), 32'h1 << ((k / QUANTUM) % NCH));
            tick();
            check("fair.vld", 32'(out_valid), 32'd1);
            check("fair.ch",  32'(out_ch),    32'((k / QUANTUM) % NCH));
        end

        // Owner drop: ch2 owns with cnt=2, then ch0 and ch3 request.
        do_reset();
        drive(4'b0100, 4'b0000, 4'b0000); tick(); check_out("drop1", 2'd2, 3'd3, 1'b0);
        drive(4'b0100, 4'b0000, 4'b0000); tick(); check_out("drop2", 2'd2, 3'd3, 1'b0);
        drive(4'b1001, 4'b0000, 4'b0000);
        check("drop3.ready", 32'(req_ready), 32'b1000);
        tick(); check_out("drop3", 2'd3, 3'd3, 1'b0);
        drive(4'b1001, 4'b0000, 4'b0000);
        check("drop4.ready", 32'(req_ready), 32'b1000);
        tick();

        // Single channel runs past QUANTUM without gaps.
        for (int k = 0; k < 6; k++) begin
            drive(4'b0001, 4'b0001, 4'b0000);
            check("solo.ready", 32'(req_ready), 32'b0001);
            tick();
            check("solo.vld", 32'(out_valid), 32'd1);
        end

        // Asynchronous reset mid-burst clears everything immediately.
        drive(4'b0001, 4'b0001, 4'b0000);
        tick();
        #2;
        reset_n = 1'b0;
        #1;
        check("arst.vld",   32'(out_valid), 32'd0);
        check("arst.ch",    32'(out_ch),    32'd0);
        check("arst.st",    32'(out_state), 32'd0);
        check("arst.m",     32'(out_match), 32'd0);
        check("arst.match", 32'(match),     32'h0);
        check("arst.ready", 32'(req_ready), 32'h0);
        @(negedge clk);
        reset_n   = 1'b1;
        req_valid = 4'b0001;
        req_bit   = 4'b0000;
        clr       = 4'b0000;
        #1;
        check("rel.ready", 32'(req_ready), 32'b0001);
        tick(); check_out("rel", 2'd0, 3'd3, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
